// File: rtl/usb_stream_bridge.sv
// usb_stream_bridge
//   Buffered bridge between the USB UART byte streams and the CPU bus.
//   Host bytes land in an RX FIFO the CPU drains through the DATA register.
//   CPU writes to DATA fill a show-ahead TX FIFO that streams back to the host.
//   The CPU sees four 16-bit registers with registered read data:
//     0 DATA       read pops RX (bit 15 set when empty), write pushes TX
//     1 STATUS     {rx_count[7:0], 3'b0, rx_udf, tx_ovf, tx_empty, tx_space, rx_avail}
//     2 CTRL       [0] rx_irq_en, [1] tx_irq_en, [2] rx_flush, [3] tx_flush (strobes)
//     3 RX_THRESH  [8:0] rx irq threshold, 0 behaves as 1
// Ports:
//   clk, rst                         single clock, synchronous active-high reset
//   host_rx_data/valid/ready         host -> bridge byte stream
//   host_tx_data/valid/ready         bridge -> host byte stream
//   bus_addr/re/we/wdata/rdata       CPU register bus
//   irq                              registered level interrupt

// Simple circular FIFO with a combinational head (show-ahead) output.
// Flush overrides any push or pop in the same cycle.
module usb_stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // A push into a full FIFO is still legal when the head leaves in the same
  // cycle: the freed slot is the one being written.
  assign do_pop  = pop  & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

module usb_stream_bridge #(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] host_rx_data,
  input  logic              host_rx_valid,
  output logic              host_rx_ready,
  output logic [DATA_W-1:0] host_tx_data,
  output logic              host_tx_valid,
  input  logic              host_tx_ready,
  input  logic [1:0]        bus_addr,
  input  logic              bus_re,
  input  logic              bus_we,
  input  logic [15:0]       bus_wdata,
  output logic [15:0]       bus_rdata,
  output logic              irq
);
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  logic [DATA_W-1:0] rx_head;
  logic [RX_CW-1:0]  rx_count;
  logic              rx_full, rx_empty;
  logic [TX_CW-1:0]  tx_count;
  logic              tx_full, tx_empty;

  logic              rx_push, rx_pop, tx_push, tx_pop;
  logic              rx_flush, tx_flush;
  logic              rd_data, wr_data, wr_status, wr_ctrl, wr_thresh;
  logic              tx_drop;

  logic              tx_ovf, rx_udf;
  logic              rx_irq_en, tx_irq_en;
  logic [8:0]        rx_thresh;
  logic [8:0]        thresh_eff;
  logic [15:0]       rx_count_w;
  logic [7:0]        rx_count_sat;
  logic [15:0]       status_word;
  logic [15:0]       rdata_next;
  logic              irq_cond;

  // Bus decode
  assign rd_data   = bus_re & (bus_addr == REG_DATA);
  assign wr_data   = bus_we & (bus_addr == REG_DATA);
  assign wr_status = bus_we & (bus_addr == REG_STATUS);
  assign wr_ctrl   = bus_we & (bus_addr == REG_CTRL);
  assign wr_thresh = bus_we & (bus_addr == REG_THRESH);

  assign rx_flush = wr_ctrl & bus_wdata[2];
  assign tx_flush = wr_ctrl & bus_wdata[3];

  // Host side handshakes. Ready is held low for the reset cycle itself.
  assign host_rx_ready = ~rx_full & ~rst;
  assign rx_push       = host_rx_valid & host_rx_ready;
  assign host_tx_valid = ~tx_empty;
  assign tx_pop        = host_tx_valid & host_tx_ready;

  // CPU side FIFO actions
  assign rx_pop  = rd_data & ~rx_empty;
  assign tx_push = wr_data;
  // Write lost only when full and the host is not draining this cycle.
  assign tx_drop = wr_data & tx_full & ~tx_pop & ~tx_flush;

  usb_stream_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (rx_flush),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (host_rx_data),
    .head  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  usb_stream_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (tx_flush),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (bus_wdata[DATA_W-1:0]),
    .head  (host_tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // STATUS only has 8 bits for the RX level; deeper FIFOs saturate.
  assign rx_count_w   = 16'(rx_count);
  assign rx_count_sat = (rx_count_w > 16'd255) ? 8'hFF : rx_count_w[7:0];
  assign thresh_eff   = (rx_thresh == 9'd0) ? 9'd1 : rx_thresh;

  assign status_word = {rx_count_sat, 3'b000, rx_udf, tx_ovf,
                        tx_empty, ~tx_full, ~rx_empty};

  assign irq_cond = (rx_irq_en & (rx_count_w >= {7'b0, thresh_eff}))
                  | (tx_irq_en & tx_empty);

  // Read mux sees pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rdata_next = '0;
    case (bus_addr)
      REG_DATA:   rdata_next = rx_empty ? 16'h8000
                                        : {{(16-DATA_W){1'b0}}, rx_head};
      REG_STATUS: rdata_next = status_word;
      REG_CTRL:   rdata_next = {14'b0, tx_irq_en, rx_irq_en};
      REG_THRESH: rdata_next = {7'b0, rx_thresh};
      default:    rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata <= '0;
      irq       <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_udf    <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
      rx_thresh <= 9'd1;
    end else begin
      if (bus_re) bus_rdata <= rdata_next;

      // DATA and STATUS are distinct addresses, so set/clear never collide.
      if (rd_data && rx_empty)             rx_udf <= 1'b1;
      else if (wr_status && bus_wdata[4])  rx_udf <= 1'b0;

      if (tx_drop)                         tx_ovf <= 1'b1;
      else if (wr_status && bus_wdata[3])  tx_ovf <= 1'b0;

      if (wr_ctrl) begin
        rx_irq_en <= bus_wdata[0];
        tx_irq_en <= bus_wdata[1];
      end

      if (wr_thresh) rx_thresh <= bus_wdata[8:0];

      irq <= irq_cond;
    end
  end

  // Write-data bits above the widest field and the TX level have no reader.
  logic unused_bits;
  assign unused_bits = ^{bus_wdata[15:9], tx_count};
endmodule

// File: tb/tb_usb_stream_bridge.sv
// Self-checking bench for usb_stream_bridge: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_usb_stream_bridge;
  localparam int DW  = 8;
  localparam int RXD = 16;
  localparam int TXD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] host_rx_data;
  logic          host_rx_valid;
  logic          host_rx_ready;
  logic [DW-1:0] host_tx_data;
  logic          host_tx_valid;
  logic          host_tx_ready;
  logic [1:0]    bus_addr;
  logic          bus_re, bus_we;
  logic [15:0]   bus_wdata;
  logic [15:0]   bus_rdata;
  logic          irq;

  usb_stream_bridge #(.DATA_W(DW), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk(clk), .rst(rst),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .bus_addr(bus_addr), .bus_re(bus_re), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] tx_q[$];
  bit            m_ovf, m_udf, m_rxen, m_txen, m_irq;
  logic [8:0]    m_thr;
  logic [15:0]   m_rdata;
  int            m_eff;
  bit            m_nirq, m_rxacc, m_txpop, m_rxpop, m_rxfl, m_txfl, m_acc;
  logic [7:0]    m_sat;

  always @(posedge clk) begin
    if (rst) begin
      rx_q.delete(); tx_q.delete();
      m_ovf = 0; m_udf = 0; m_rxen = 0; m_txen = 0; m_irq = 0;
      m_thr = 9'd1; m_rdata = 16'h0;
    end else begin
      m_eff   = (m_thr == 0) ? 1 : int'(m_thr);
      m_nirq  = (m_rxen && rx_q.size() >= m_eff) || (m_txen && tx_q.size() == 0);
      m_rxacc = host_rx_valid && (rx_q.size() < RXD);
      m_txpop = host_tx_ready && (tx_q.size() > 0);
      m_rxfl  = bus_we && bus_addr == 2 && bus_wdata[2];
      m_txfl  = bus_we && bus_addr == 2 && bus_wdata[3];
      m_rxpop = 0;
      if (bus_re) begin
        case (bus_addr)
          2'd0: if (rx_q.size() > 0) begin
                  m_rdata = {8'h00, rx_q[0]}; m_rxpop = 1;
                end else begin
                  m_rdata = 16'h8000; m_udf = 1;
                end
          2'd1: begin
                  m_sat = (rx_q.size() > 255) ? 8'hFF : 8'(rx_q.size());
                  m_rdata = {m_sat, 3'b000, m_udf, m_ovf, tx_q.size() == 0,
                             tx_q.size() < TXD, rx_q.size() > 0};
                end
          2'd2: m_rdata = {14'b0, m_txen, m_rxen};
          default: m_rdata = {7'b0, m_thr};
        endcase
      end
      if (bus_we) begin
        case (bus_addr)
          2'd1: begin
                  if (bus_wdata[3]) m_ovf = 0;
                  if (bus_wdata[4]) m_udf = 0;
                end
          2'd2: begin m_rxen = bus_wdata[0]; m_txen = bus_wdata[1]; end
          2'd3: m_thr = bus_wdata[8:0];
          default: ;
        endcase
      end
      if (m_rxfl) rx_q.delete();
      else begin
        if (m_rxpop) void'(rx_q.pop_front());
        if (m_rxacc) rx_q.push_back(host_rx_data);
      end
      if (m_txfl) tx_q.delete();
      else begin
        m_acc = 0;
        if (bus_we && bus_addr == 0) begin
          if (tx_q.size() < TXD || m_txpop) m_acc = 1;
          else m_ovf = 1;
        end
        if (m_txpop) void'(tx_q.pop_front());
        if (m_acc) tx_q.push_back(bus_wdata[DW-1:0]);
      end
      m_irq = m_nirq;
    end
  end

  // Every-cycle comparison, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    chk("host_rx_ready", host_rx_ready, !rst && rx_q.size() < RXD);
    chk("host_tx_valid", host_tx_valid, tx_q.size() > 0);
    if (tx_q.size() > 0) chk("host_tx_data", host_tx_data, tx_q[0]);
    chk("bus_rdata", bus_rdata, m_rdata);
    chk("irq", irq, m_irq);
  end

  // Bytes actually delivered to the host.
  logic [DW-1:0] seen[$];
  always @(posedge clk)
    if (!rst && host_tx_valid && host_tx_ready) seen.push_back(host_tx_data);

  // ---------------- stimulus helpers ----------------
  task automatic host_push(input logic [DW-1:0] d);
    host_rx_data = d; host_rx_valid = 1'b1;
    @(negedge clk);
    host_rx_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    d = bus_rdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  logic [15:0] rd;
  int          acc;

  initial begin
    rst = 1'b1; host_rx_data = '0; host_rx_valid = 1'b0; host_tx_ready = 1'b0;
    bus_addr = '0; bus_re = 1'b0; bus_we = 1'b0; bus_wdata = '0;
    @(negedge clk);
    chk("ready_in_reset", host_rx_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rdata", bus_rdata, 16'h0000);
    chk("reset_irq", irq, 1'b0);
    chk("reset_tx_valid", host_tx_valid, 1'b0);
    chk("ready_after_reset", host_rx_ready, 1'b1);

    // Host sends two bytes, CPU drains them and underflows once.
    host_push(8'h41); host_push(8'h42);
    bus_read(2'd1, rd); chk("status_two_bytes", rd, 16'h0207);
    bus_read(2'd0, rd); chk("data_0x41", rd, 16'h0041);
    bus_read(2'd0, rd); chk("data_0x42", rd, 16'h0042);
    bus_read(2'd0, rd); chk("data_empty", rd, 16'h8000);
    bus_read(2'd1, rd); chk("status_udf", rd, 16'h0016);
    bus_write(2'd1, 16'h0010);
    bus_read(2'd1, rd); chk("status_udf_clr", rd, 16'h0006);

    // TX overflow: 17 writes into a 16-deep FIFO with the host stalled.
    seen.delete();
    for (int i = 0; i < 17; i++) bus_write(2'd0, 16'(i));
    bus_read(2'd1, rd); chk("status_tx_ovf", rd, 16'h0008);
    host_tx_ready = 1'b1;
    repeat (20) @(negedge clk);
    host_tx_ready = 1'b0;
    chk("tx_seen_count", seen.size(), 16);
    for (int i = 0; i < 16 && i < seen.size(); i++) chk("tx_seen_byte", seen[i], 8'(i));
    bus_write(2'd1, 16'h0008);

    // Full TX FIFO: write in the same cycle as a host pop is accepted.
    seen.delete();
    for (int i = 0; i < 16; i++) bus_write(2'd0, 16'h20 + 16'(i));
    bus_read(2'd1, rd); chk("status_tx_full", rd, 16'h0000);
    host_tx_ready = 1'b1; bus_addr = 2'd0; bus_wdata = 16'h0099; bus_we = 1'b1;
    @(negedge clk);
    host_tx_ready = 1'b0; bus_we = 1'b0;
    bus_read(2'd1, rd); chk("status_full_no_ovf", rd, 16'h0000);
    chk("pop_with_write", seen.size() == 1 && seen[0] == 8'h20, 1'b1);
    bus_write(2'd2, 16'h0008);
    chk("tx_flush_valid", host_tx_valid, 1'b0);
    bus_read(2'd1, rd); chk("status_tx_flushed", rd, 16'h0006);

    // RX backpressure: 20 offered, 16 taken.
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      host_rx_data = 8'(8'h60 + i); host_rx_valid = 1'b1;
      if (host_rx_ready) acc++;
      @(negedge clk);
    end
    host_rx_valid = 1'b0;
    chk("rx_accepted", acc, 16);
    chk("rx_ready_full", host_rx_ready, 1'b0);
    bus_read(2'd0, rd); chk("rx_first", rd, 16'h0060);
    chk("rx_ready_one_slot", host_rx_ready, 1'b1);
    host_push(8'hAA);
    chk("rx_ready_full_again", host_rx_ready, 1'b0);
    bus_write(2'd2, 16'h0004);
    bus_read(2'd1, rd); chk("status_rx_flushed", rd, 16'h0006);

    // Threshold interrupt.
    bus_write(2'd3, 16'd4);
    bus_write(2'd2, 16'h0001);
    for (int i = 0; i < 3; i++) host_push(8'(i));
    chk("irq_below_thresh", irq, 1'b0);
    host_push(8'h03);
    chk("irq_same_cycle", irq, 1'b0);
    @(negedge clk);
    chk("irq_rise", irq, 1'b1);
    bus_read(2'd0, rd);
    chk("irq_hold", irq, 1'b1);
    @(negedge clk);
    chk("irq_fall", irq, 1'b0);
    // Threshold 0 behaves as 1.
    bus_write(2'd2, 16'h0004);
    bus_write(2'd3, 16'd0);
    bus_write(2'd2, 16'h0001);
    host_push(8'h55);
    @(negedge clk);
    chk("irq_thresh0", irq, 1'b1);
    bus_write(2'd2, 16'h0004);

    // Reset with data in both FIFOs.
    host_push(8'h11); host_push(8'h12);
    bus_write(2'd0, 16'h0033); bus_write(2'd0, 16'h0034);
    bus_write(2'd2, 16'h0003);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_read(2'd1, rd); chk("status_after_rst", rd, 16'h0006);
    chk("irq_after_rst", irq, 1'b0);
    chk("tx_valid_after_rst", host_tx_valid, 1'b0);

    // Randomized traffic, checked each cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      host_rx_valid = ($urandom_range(0, 1) == 1);
      host_rx_data  = 8'($urandom);
      host_tx_ready = ($urandom_range(0, 2) == 0);
      bus_re        = ($urandom_range(0, 2) == 0);
      bus_we        = ($urandom_range(0, 2) == 0);
      bus_addr      = 2'($urandom_range(0, 3));
      bus_wdata     = 16'($urandom);
      if (bus_addr == 2'd3) bus_wdata = 16'($urandom_range(0, 17));
      if (bus_addr == 2'd2 && $urandom_range(0, 3) != 0) bus_wdata[3:2] = 2'b00;
      @(negedge clk);
    end
    rst = 1'b0; host_rx_valid = 1'b0; bus_re = 1'b0; bus_we = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/usb_stream_bridge.md
Name: usb_stream_bridge

Overview:
Parametrised bridge between the USB UART byte streams and the Boneless CPU. Replaces the fixed packed 16-bit status/data word wiring with buffered FIFOs in both directions. Presents a 4-register, 16-bit, single-cycle-read bus to the CPU, with sticky error flags, flush controls and a level-triggered interrupt. Sits between usb_uart_i40 (on clk_48mhz) and boneless_core in the top level.

Parameters:
DATA_W, 8, stream byte width; legal range 1..15.
RX_DEPTH, 16, host-to-CPU FIFO entries; power of 2, 2..256.
TX_DEPTH, 16, CPU-to-host FIFO entries; power of 2, 2..256.

Ports:
clk  in  1  system clock; the single clock for the whole block.
rst  in  1  synchronous, active-high reset.
host_rx_data  in  DATA_W  byte from host; connects to uart_out_data.
host_rx_valid  in  1  host byte valid.
host_rx_ready  out  1  bridge can accept a host byte.
host_tx_data  out  DATA_W  byte to host; connects to uart_in_data.
host_tx_valid  out  1  TX FIFO head valid.
host_tx_ready  in  1  UART accepts the head byte.
bus_addr  in  2  register select.
bus_re  in  1  read strobe.
bus_we  in  1  write strobe.
bus_wdata  in  16  write data.
bus_rdata  out  16  registered read data.
irq  out  1  level interrupt to CPU.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. All state is cleared on the clk edge where rst=1.
- Reset state:
  - FIFOs empty; sticky flags 0; CTRL=0; RX_THRESH=1.
  - Outputs: bus_rdata=0, irq=0, host_tx_valid=0.
  - host_rx_ready=0 while rst=1, then 1 from the first cycle after reset.
  - Reset mid-transfer discards all buffered data.
- RX FIFO:
  - host_rx_ready = !rx_full.
  - Push on host_rx_valid & host_rx_ready.
  - No overflow is possible; backpressure only.
- TX FIFO (show-ahead):
  - host_tx_valid = !tx_empty; host_tx_data = head entry.
  - Pop on host_tx_valid & host_tx_ready.
  - host_tx_data must remain stable while host_tx_valid=1 and host_tx_ready=0.
- Simultaneous push and pop on one FIFO: both occur and the count is unchanged.
  - A CPU write to a full TX FIFO is accepted if a host pop happens in the same cycle.
- Register map, bus_addr:
  - 0 DATA:
    - Read, RX non-empty: returns {1'b0, zeros, rx_byte} and pops.
    - Read, RX empty: returns 16'h8000, no pop, sets sticky rx_udf.
    - Write: pushes bus_wdata[DATA_W-1:0]. If the FIFO is full with no same-cycle pop, the data is dropped and sticky tx_ovf is set.
  - 1 STATUS, read is non-destructive:
    - [0] rx_avail, [1] tx_space, [2] tx_empty, [3] tx_ovf, [4] rx_udf, [7:5] 0.
    - [15:8] rx_count, saturated at 255.
    - Write 1 to bit 3 or bit 4 clears that flag; other bits are ignored.
  - 2 CTRL:
    - [0] rx_irq_en, [1] tx_irq_en.
    - [2] rx_flush, [3] tx_flush: write-1 strobes, read as 0.
    - Flush empties the FIFO in that cycle. Flush beats a same-cycle push or pop; that push is discarded and no flag is set.
  - 3 RX_THRESH: [8:0] threshold, R/W. A value of 0 is treated as 1.
- Read timing:
  - bus_rdata is updated on the edge after bus_re and holds until the next read.
  - A read with bus_we in the same cycle returns the pre-write state; both actions take effect.
- irq is registered, one cycle after the condition: (rx_irq_en & rx_count >= RX_THRESH) | (tx_irq_en & tx_empty).
- Count widths are log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

Test Plan:
- Reset, then host sends 0x41,0x42 -> STATUS reads 0x0207; two DATA reads return 0x0041, then 0x0042; a third returns 0x8000 and STATUS bit4=1.
- CPU writes 17 bytes (0x00..0x10) with host_tx_ready=0 at TX_DEPTH=16 -> tx_ovf=1. Release ready -> host sees 0x00..0x0F in order; 0x10 is absent.
- Host streams 20 bytes with RX_DEPTH=16 and no CPU reads -> host_rx_ready falls after the 16th byte. One DATA read -> ready=1 for exactly one more byte.
- RX_THRESH=4, rx_irq_en=1 -> irq rises one cycle after the 4th byte is pushed; one DATA read -> irq falls on the following cycle.
- TX full, CPU write in the same cycle as a host pop -> write accepted, count stays 16, tx_ovf stays 0. Write CTRL=0x08 -> tx_empty=1 and host_tx_valid=0 next cycle.
- rst asserted while both FIFOs hold data -> next cycle STATUS=0x0006, irq=0, host_tx_valid=0.
